// File: rtl/receive.sv
// ============================================================================
// Module   : receive
// Purpose  : 8N1 UART receiver with strobe/ready byte handshake and
//            framing/overrun error pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module receive #(
    parameter int BAUDRATE  = 9600,
    parameter int FREQUENCY = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       stb,
    output logic [7:0] dat,
    input  logic       rdy,
    output logic       err
);

    localparam int c_DIV  = FREQUENCY / BAUDRATE;
    localparam int c_HALF = c_DIV / 2;
    localparam int c_CW   = $clog2(c_DIV);

    localparam logic [c_CW-1:0] c_DIV_M1  = c_CW'(c_DIV - 1);
    localparam logic [c_CW-1:0] c_HALF_M1 = c_CW'(c_HALF - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    logic            r_sync1;
    logic            r_sync2;
    logic            r_prev;
    logic [1:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [2:0]      r_idx;
    logic [7:0]      r_shift;
    logic            r_stb;
    logic [7:0]      r_dat;
    logic            r_err;

    logic w_rxs;
    logic w_tick;

    assign w_rxs  = r_sync2;
    assign w_tick = (r_cnt == '0);

    assign stb = r_stb;
    assign dat = r_dat;
    assign err = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_shift <= 8'd0;
            r_stb   <= 1'b0;
            r_dat   <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_err   <= 1'b0;

            if (r_stb && rdy)
                r_stb <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    // Only a genuine 1->0 transition arms the receiver, so a held break is ignored.
                    if (r_prev && !w_rxs) begin
                        r_cnt   <= c_HALF_M1;
                        r_state <= c_START;
                    end
                end
                c_START: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (w_rxs) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_cnt   <= c_DIV_M1;
                        r_idx   <= 3'd0;
                        r_state <= c_DATA;
                    end
                end
                c_DATA: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_shift <= {w_rxs, r_shift[7:1]};
                        r_cnt   <= c_DIV_M1;
                        r_idx   <= r_idx + 3'd1;
                        if (r_idx == 3'd7)
                            r_state <= c_STOP;
                    end
                end
                default: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        // Leaving at mid-stop-bit lets an immediately following start bit be caught.
                        r_state <= c_IDLE;
                        if (w_rxs && (!r_stb || rdy)) begin
                            r_dat <= r_shift;
                            r_stb <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_receive.sv
// ============================================================================
// Module   : tb_receive
// Purpose  : Directed self-checking bench for the receive UART block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_receive;

    localparam int c_FREQ = 1000000;
    localparam int c_BAUD = 100000;
    localparam int c_DIV  = c_FREQ / c_BAUD;

    logic       clk;
    logic       rst;
    logic       rxd;
    logic       stb;
    logic [7:0] dat;
    logic       rdy;
    logic       err;

    int n_cmp;
    int n_bad;

    logic [7:0] rx_q[$];
    int         stb_cycles;
    int         err_cnt;
    int         err_wide;
    logic       r_err_d;

    receive #(
        .BAUDRATE (c_BAUD),
        .FREQUENCY(c_FREQ)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rxd(rxd),
        .stb(stb),
        .dat(dat),
        .rdy(rdy),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        stb_cycles = 0;
        err_cnt    = 0;
        err_wide   = 0;
        r_err_d    = 1'b0;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (stb) stb_cycles = stb_cycles + 1;
            if (stb && rdy) rx_q.push_back(dat);
            if (err) err_cnt = err_cnt + 1;
            if (err && r_err_d) err_wide = err_wide + 1;
        end
        r_err_d = err;
    end

    task automatic ser_bit(input logic b);
        rxd = b;
        repeat (c_DIV) @(posedge clk);
        #1;
    endtask

    task automatic ser_byte(input logic [7:0] d, input logic stop);
        ser_bit(1'b0);
        for (int i = 0; i < 8; i++) ser_bit(d[i]);
        ser_bit(stop);
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rxd = 1'b1;
        rdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (stb !== 1'b0)  begin n_bad++; $display("FAIL reset_stb got %b want 0", stb); end
        n_cmp++; if (dat !== 8'h00) begin n_bad++; $display("FAIL reset_dat got %h want 00", dat); end
        n_cmp++; if (err !== 1'b0)  begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
        @(posedge clk); #1;
        rst = 1'b0;
        idle(5);
    endtask

    task automatic test_single;
        int q0, s0, e0;
        q0 = rx_q.size(); s0 = stb_cycles; e0 = err_cnt;
        rdy = 1'b1;
        ser_byte(8'hA5, 1'b1);
        idle(20);
        n_cmp++; if (rx_q.size() - q0 !== 1) begin n_bad++; $display("FAIL single_count got %0d want 1", rx_q.size() - q0); end
        else begin
            n_cmp++; if (rx_q[q0] !== 8'hA5) begin n_bad++; $display("FAIL single_dat got %h want a5", rx_q[q0]); end
        end
        n_cmp++; if (stb_cycles - s0 !== 1) begin n_bad++; $display("FAIL single_stb_width got %0d want 1", stb_cycles - s0); end
        n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL single_err got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_back_to_back;
        int q0, e0;
        q0 = rx_q.size(); e0 = err_cnt;
        rdy = 1'b1;
        ser_byte(8'h00, 1'b1);
        ser_byte(8'hFF, 1'b1);
        idle(20);
        n_cmp++; if (rx_q.size() - q0 !== 2) begin n_bad++; $display("FAIL b2b_count got %0d want 2", rx_q.size() - q0); end
        else begin
            n_cmp++; if (rx_q[q0] !== 8'h00)   begin n_bad++; $display("FAIL b2b_first got %h want 00", rx_q[q0]); end
            n_cmp++; if (rx_q[q0+1] !== 8'hFF) begin n_bad++; $display("FAIL b2b_second got %h want ff", rx_q[q0+1]); end
        end
        n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL b2b_err got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_glitch;
        int q0, e0;
        q0 = rx_q.size(); e0 = err_cnt;
        rdy = 1'b1;
        rxd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle(150);
        n_cmp++; if (rx_q.size() - q0 !== 0) begin n_bad++; $display("FAIL glitch_count got %0d want 0", rx_q.size() - q0); end
        n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL glitch_err got %0d want 0", err_cnt - e0); end
        // A real frame right after must still be received, proving the FSM is idle.
        ser_byte(8'h81, 1'b1);
        idle(20);
        n_cmp++; if (rx_q.size() - q0 !== 1) begin n_bad++; $display("FAIL glitch_recover_count got %0d want 1", rx_q.size() - q0); end
        else begin
            n_cmp++; if (rx_q[q0] !== 8'h81) begin n_bad++; $display("FAIL glitch_recover_dat got %h want 81", rx_q[q0]); end
        end
    endtask

    task automatic test_framing;
        int q0, e0, w0, s0;
        q0 = rx_q.size(); e0 = err_cnt; w0 = err_wide; s0 = stb_cycles;
        rdy = 1'b1;
        ser_byte(8'h3C, 1'b0);
        idle(30);
        n_cmp++; if (err_cnt - e0 !== 1)   begin n_bad++; $display("FAIL frame_err_count got %0d want 1", err_cnt - e0); end
        n_cmp++; if (err_wide - w0 !== 0)  begin n_bad++; $display("FAIL frame_err_width got %0d want 0", err_wide - w0); end
        n_cmp++; if (stb_cycles - s0 !== 0) begin n_bad++; $display("FAIL frame_stb got %0d want 0", stb_cycles - s0); end
        n_cmp++; if (dat !== 8'h81)        begin n_bad++; $display("FAIL frame_dat_held got %h want 81", dat); end
        ser_byte(8'h3C, 1'b1);
        idle(20);
        n_cmp++; if (rx_q.size() - q0 !== 1) begin n_bad++; $display("FAIL frame_valid_count got %0d want 1", rx_q.size() - q0); end
        else begin
            n_cmp++; if (rx_q[q0] !== 8'h3C) begin n_bad++; $display("FAIL frame_valid_dat got %h want 3c", rx_q[q0]); end
        end
    endtask

    task automatic test_overrun;
        int q0, e0;
        q0 = rx_q.size(); e0 = err_cnt;
        rdy = 1'b0;
        ser_byte(8'h11, 1'b1);
        ser_byte(8'h22, 1'b1);
        idle(20);
        @(negedge clk);
        n_cmp++; if (stb !== 1'b1)        begin n_bad++; $display("FAIL overrun_stb got %b want 1", stb); end
        n_cmp++; if (dat !== 8'h11)       begin n_bad++; $display("FAIL overrun_dat got %h want 11", dat); end
        n_cmp++; if (err_cnt - e0 !== 1)  begin n_bad++; $display("FAIL overrun_err got %0d want 1", err_cnt - e0); end
        @(posedge clk); #1;
        rdy = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (rx_q.size() - q0 !== 1) begin n_bad++; $display("FAIL overrun_xfer_count got %0d want 1", rx_q.size() - q0); end
        else begin
            n_cmp++; if (rx_q[q0] !== 8'h11) begin n_bad++; $display("FAIL overrun_xfer_dat got %h want 11", rx_q[q0]); end
        end
        n_cmp++; if (stb !== 1'b0) begin n_bad++; $display("FAIL overrun_stb_clear got %b want 0", stb); end
        idle(5);
    endtask

    task automatic test_reset_midframe;
        int q0, e0;
        q0 = rx_q.size(); e0 = err_cnt;
        rdy = 1'b1;
        // 0x5A: start, bit0=0, then bit1=1 during which reset hits
        ser_bit(1'b0);
        ser_bit(1'b0);
        rxd = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (stb !== 1'b0)  begin n_bad++; $display("FAIL rstmid_stb got %b want 0", stb); end
        n_cmp++; if (dat !== 8'h00) begin n_bad++; $display("FAIL rstmid_dat got %h want 00", dat); end
        idle(150);
        ser_byte(8'h96, 1'b1);
        idle(20);
        n_cmp++; if (rx_q.size() - q0 !== 1) begin n_bad++; $display("FAIL rstmid_count got %0d want 1", rx_q.size() - q0); end
        else begin
            n_cmp++; if (rx_q[q0] !== 8'h96) begin n_bad++; $display("FAIL rstmid_dat_rx got %h want 96", rx_q[q0]); end
        end
        n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL rstmid_err got %0d want 0", err_cnt - e0); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        rxd   = 1'b1;
        rdy   = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_overrun();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/receive.md
Name: receive

Overview:
- Serial receive stage (8N1 UART receiver) that sits directly downstream of the `transmit` block.
- Samples the asynchronous `rxd` line and reconstructs 8-bit bytes.
- Presents each byte on a strobe/ready handshake matching the `transmit` input interface, so a loopback pair `transmit` → `receive` forms the serial link of the design.
- Flags framing errors and overruns.

Parameters:
- BAUDRATE, 9600: serial bit rate in bits/s.
- FREQUENCY, 50000000: `clk` frequency in Hz.
- Derived, not overridable: DIV = FREQUENCY/BAUDRATE (integer division, must be ≥ 4); HALF = DIV/2.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  reset, synchronous, active-high.
- rxd  input  1  serial line; idles high; asynchronous to clk.
- stb  output 1  received byte valid.
- dat  output 8  received byte, LSB = first data bit on the wire.
- rdy  input  1  consumer ready; a byte transfers on a cycle where stb && rdy.
- err  output 1  one-cycle pulse on framing error or overrun.

Behaviour:
- Reset values (rst sampled high at a clk edge):
  - stb=0, dat=0, err=0.
  - Synchronizer flops and edge-history flop = 1.
  - FSM=IDLE; bit counter=0; baud counter=0.
- rst has priority over every other event, including a frame in progress and a pending stb; a partial frame is discarded.
- Input conditioning: 2-flop synchronizer on rxd gives `rxs`. A third flop holds `rxs` delayed by one cycle for falling-edge detection.
- IDLE:
  - On falling edge of rxs (prev=1, cur=0): load baud counter with HALF-1 and go to START.
  - A line held low (break) never re-arms; a new 1→0 edge is required.
- START: count down to 0, then sample rxs at the mid-bit point.
  - rxs=1: false start; return to IDLE, no err.
  - rxs=0: load DIV-1, clear bit index, go to DATA.
- DATA: at each baud-counter zero, sample rxs and shift it in LSB-first (shift right, new bit at MSB), then reload DIV-1.
  - After the 8th sample (bit index 7), go to STOP with DIV-1 loaded.
- STOP: at counter zero, sample rxs, then go to IDLE.
  - rxs=1 and (stb=0, or stb&&rdy this cycle): dat ← shift register; stb=1 next cycle.
  - rxs=1 and stb=1 with rdy=0 (overrun): new byte dropped; held byte and stb unchanged; err=1 for one cycle.
  - rxs=0 (framing error): byte dropped; err=1 for one cycle; stb/dat unchanged.
- Latency: stb rises on the clk edge following the stop-bit mid-sample, about 9.5 bit times after the start-bit falling edge plus 2 synchronizer cycles.
- Handshake:
  - stb stays high and dat stays stable until a cycle with stb&&rdy.
  - stb clears on the next edge, unless a new byte loads on that same edge; then stb stays 1 and dat updates.
  - rdy is ignored while stb=0.
- Back-to-back frames: the receiver returns to IDLE at mid-stop-bit, so a start bit immediately following the stop bit is detected.
- Baud counter width: clog2(DIV). Bit index: 3 bits.

Test Plan:
- Bench setup: FREQUENCY=1000000, BAUDRATE=100000 (DIV=10); drive rxd with the existing `ser_` serial tasks and `transmit`-style framing.
- Single byte 0xA5 sent, rdy=1 → stb pulses exactly one cycle with dat=0xA5; err stays 0.
- Two back-to-back bytes 0x00 then 0xFF (no idle gap), rdy=1 → two stb transfers carrying 0x00 then 0xFF, in order.
- Glitch: rxd low for 3 cycles (< HALF) then high → FSM returns to IDLE; no stb; no err.
- Framing: byte 0x3C sent with stop bit forced 0 → err one-cycle pulse; stb stays 0; dat unchanged. Then a valid 0x3C → stb with dat=0x3C.
- Overrun: rdy=0; send 0x11 then 0x22 → stb=1 with dat=0x11 held; err pulses at the 0x22 stop bit. Raise rdy → one transfer of 0x11, then stb=0.
- Reset mid-frame: assert rst during DATA of byte 0x5A for one cycle, then send 0x96 → only 0x96 delivered; stb=0 and dat=0 in the cycle after rst.
